piso_shift_reg: RTL and testbench

Parallel-in, serial-out shifter with a valid/ready load handshake and a framed serial output. It is the transmit-side counterpart of the 4-bit SIPO shift register. With default parameters, a word loaded here and shifted for WIDTH cycles into the SIPO reappears unchanged on the SIPO's parallel output. It sits between a parallel data source and a 1-bit serial link.

---
 rtl/piso_shift_reg_pkg.sv | 22 ++
 rtl/piso_shift_reg.sv | 88 ++++++++
 tb/tb_piso_shift_reg.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_reg_pkg.sv
// Shared definitions for the PISO transmitter and its SIPO counterpart:
// the frame state encoding, the common default word width and a count-width helper.
package piso_shift_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to count 0..value-1; evaluated at elaboration time.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter: a valid/ready handshake loads a word, which is
// then sent one bit per clock with so_valid framing and so_last marking the final bit.
module piso_shift_reg
  import piso_shift_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             ready_en;
  logic             at_last;
  logic             load;
  logic             so_n, so_valid_n, so_last_n;

  function automatic logic end_bit(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? word[0] : word[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? {1'b0, word[WIDTH-1:1]} : {word[WIDTH-2:0], 1'b0};
  endfunction

  // ready_en holds pi_ready low through reset and for the first edge after it.
  assign at_last  = (state == SHIFT) && (cnt == LAST_CNT);
  assign pi_ready = ready_en && ((state == IDLE) || at_last);
  assign load     = pi_valid && pi_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sreg_n  = pi;
    end else if (state == SHIFT) begin
      if (at_last) begin
        state_n = IDLE;
      end else begin
        cnt_n  = cnt + CNT_W'(1);
        sreg_n = shift_word(sreg);
      end
    end
    // Serial outputs are computed from next-state values so they can be registered.
    so_valid_n = (state_n == SHIFT);
    so_n       = so_valid_n && end_bit(sreg_n);
    so_last_n  = so_valid_n && (cnt_n == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ready_en <= 1'b0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      so_last  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ready_en <= 1'b1;
      so       <= so_n;
      so_valid <= so_valid_n;
      so_last  <= so_last_n;
    end
  end

  // Payload register carries no reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    sreg <= sreg_n;
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: an LSB-first instance looped into a SIPO
// receiver model and an MSB-first instance, both checked bit by bit against a queue.
module tb_piso_shift_reg;
  import piso_shift_reg_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pi_a, pi_b;
  logic         pv_a, pv_b;
  logic         rdy_a, rdy_b;
  logic         so_a, so_b, sv_a, sv_b, sl_a, sl_b;
  logic [W-1:0] sipo;
  logic         sipo_rst;
  exp_t         q_a[$];
  exp_t         q_b[$];
  exp_t         e_a, e_b;
  int           checks = 0;
  int           passes = 0;
  int           fails  = 0;

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pi(pi_a), .pi_valid(pv_a), .pi_ready(rdy_a),
    .so(so_a), .so_valid(sv_a), .so_last(sl_a)
  );

  piso_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .pi(pi_b), .pi_valid(pv_b), .pi_ready(rdy_b),
    .so(so_b), .so_valid(sv_b), .so_last(sl_b)
  );

  // Receiver: SIPO shifting in at the top bit toward bit 0, active-high reset.
  assign sipo_rst = ~rst_n;
  always @(posedge clk or posedge sipo_rst) begin
    if (sipo_rst) sipo <= '0;
    else if (sv_a) sipo <= {so_a, sipo[W-1:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) q_a.push_back('{b: w[i], last: (i == W - 1)});
  endtask

  task automatic push_b(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) q_b.push_back('{b: w[W-1-i], last: (i == W - 1)});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a word, waits (bounded) for ready, and completes the handshake edge.
  task automatic send_a(input logic [W-1:0] w);
    int n;
    n = 0;
    pi_a = w;
    pv_a = 1'b1;
    while (!rdy_a && n < 20) begin
      step(1);
      n++;
    end
    check("a_ready_wait", rdy_a, 1);
    @(posedge clk);
    push_a(w);
    #1;
    pv_a = 1'b0;
  endtask

  task automatic send_b(input logic [W-1:0] w);
    int n;
    n = 0;
    pi_b = w;
    pv_b = 1'b1;
    while (!rdy_b && n < 20) begin
      step(1);
      n++;
    end
    check("b_ready_wait", rdy_b, 1);
    @(posedge clk);
    push_b(w);
    #1;
    pv_b = 1'b0;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (sv_a) begin
      if (q_a.size() == 0) check("a_unexpected_valid", sv_a, 0);
      else begin
        e_a = q_a.pop_front();
        check("a_so", so_a, e_a.b);
        check("a_so_last", sl_a, e_a.last);
      end
    end else begin
      check("a_idle_so", so_a, 0);
      check("a_idle_last", sl_a, 0);
    end
    if (sv_b) begin
      if (q_b.size() == 0) check("b_unexpected_valid", sv_b, 0);
      else begin
        e_b = q_b.pop_front();
        check("b_so", so_b, e_b.b);
        check("b_so_last", sl_b, e_b.last);
      end
    end else begin
      check("b_idle_so", so_b, 0);
      check("b_idle_last", sl_b, 0);
    end
  end

  initial begin
    pi_a = '0;
    pi_b = '0;
    pv_a = 1'b0;
    pv_b = 1'b0;

    // Reset and release with no handshake
    repeat (2) begin
      step(1);
      check("rst_ready_a", rdy_a, 0);
      check("rst_valid_a", sv_a, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", rdy_a, 0);
    step(1);
    check("ready_after_edge_a", rdy_a, 1);
    check("ready_after_edge_b", rdy_b, 1);

    // Single LSB-first frame into the SIPO
    send_a(4'b1011);
    for (int i = 0; i < W; i++) begin
      check("f1_valid", sv_a, 1);
      step(1);
    end
    check("f1_valid_end", sv_a, 0);
    check("f1_sipo", sipo, 4'b1011);
    check("f1_drained", q_a.size(), 0);

    // MSB-first frame
    send_b(4'b1000);
    step(W);
    check("msb_valid_end", sv_b, 0);
    check("msb_drained", q_b.size(), 0);

    // Back-to-back frames with no gap
    send_a(4'hA);
    for (int i = 0; i < W - 1; i++) begin
      check("b2b_valid_1", sv_a, 1);
      step(1);
    end
    check("b2b_valid_last", sv_a, 1);
    check("b2b_ready_last", rdy_a, 1);
    send_a(4'h5);
    check("b2b_sipo_1", sipo, 4'hA);
    for (int i = 0; i < W; i++) begin
      check("b2b_valid_2", sv_a, 1);
      step(1);
    end
    check("b2b_valid_end", sv_a, 0);
    check("b2b_sipo_2", sipo, 4'h5);
    check("b2b_drained", q_a.size(), 0);

    // pi_valid while busy is ignored, word changes underneath
    send_a(4'h6);
    step(1);
    pi_a = 4'h9;
    pv_a = 1'b1;
    check("busy_ready_bit2", rdy_a, 0);
    step(1);
    pi_a = 4'hC;
    check("busy_ready_bit3", rdy_a, 0);
    step(1);
    check("busy_ready_last", rdy_a, 1);
    check("busy_last_flag", sl_a, 1);
    @(posedge clk);
    push_a(4'hC);
    #1;
    pv_a = 1'b0;
    check("busy_sipo_1", sipo, 4'h6);
    step(W);
    check("busy_sipo_2", sipo, 4'hC);
    check("busy_drained", q_a.size(), 0);

    // Reset during bit 2 aborts the frame
    send_a(4'hF);
    step(1);
    #2;
    rst_n = 1'b0;
    q_a.delete();
    #1;
    check("abort_valid", sv_a, 0);
    check("abort_so", so_a, 0);
    check("abort_last", sl_a, 0);
    check("abort_ready", rdy_a, 0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    send_a(4'h3);
    step(W);
    check("post_abort_sipo", sipo, 4'h3);
    check("post_abort_drained", q_a.size(), 0);
    step(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
